// File: rtl/fp_normalize_pkg.sv
// Shared format selectors, field-length helpers and special-value codes
// for the floating-point datapath stages.
// Pure declarations, no logic.
package fp_normalize_pkg;

  // Format selectors
  localparam int FMT_FP16 = 0;
  localparam int FMT_FP32 = 1;
  localparam int FMT_FP64 = 2;

  // Special codes carried alongside each operand
  localparam logic [1:0] SP_NORMAL = 2'b00;
  localparam logic [1:0] SP_ZERO   = 2'b01;
  localparam logic [1:0] SP_INF    = 2'b10;
  localparam logic [1:0] SP_NAN    = 2'b11;

  function automatic int get_exp_len(input int fmt);
    case (fmt)
      FMT_FP16: return 5;
      FMT_FP64: return 11;
      default:  return 8;
    endcase
  endfunction

  function automatic int get_mantissa_len(input int fmt);
    case (fmt)
      FMT_FP16: return 10;
      FMT_FP64: return 52;
      default:  return 23;
    endcase
  endfunction

  // Guard/round/sticky
  function automatic int get_protect_len(input int fmt);
    return (fmt >= 0) ? 3 : 3;
  endfunction

endpackage

// File: rtl/fp_normalize_if.sv
// Handshake bundle between mantissa adder, normalizer and rounder.
// master = environment driving operands and out_ready, slave = normalizer.
// Carries both the upstream and downstream valid/ready pairs.
interface fp_normalize_if
  import fp_normalize_pkg::*;
#(
  parameter int DATA_FORMAT = FMT_FP32
) ();

  localparam int E = get_exp_len(DATA_FORMAT);
  localparam int M = get_mantissa_len(DATA_FORMAT);
  localparam int P = get_protect_len(DATA_FORMAT);

  // Upstream side: {carry, hidden, mantissa, protect}
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_special;
  logic             in_sign;
  logic [E-1:0]     in_exp;
  logic [M+P+1:0]   in_mant;

  // Downstream side: {hidden, mantissa, protect}, LSB sticky-merged
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_special;
  logic             out_sign;
  logic [E-1:0]     out_exp;
  logic [M+P:0]     out_mant;

  modport master (
    output in_valid, in_special, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_special, out_sign, out_exp, out_mant
  );

  modport slave (
    input  in_valid, in_special, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_special, out_sign, out_exp, out_mant
  );

endinterface

// File: rtl/fp_normalize_lzc.sv
// Leading-zero counter over a W-bit vector; all-zero input returns W.
// Latency: combinational.
// Backpressure: none, pure function of the input.
module fp_lzc #(
  parameter int W = 27
) (
  input  logic [W-1:0]           i_dat,
  output logic [$clog2(W+1)-1:0] o_cnt
);

  localparam int CW = $clog2(W + 1);

  // Scan LSB to MSB so the highest set bit makes the final assignment
  always_comb begin
    o_cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_dat[i]) o_cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalize.sv
// Normalizes the adder mantissa (carry right-shift or leading-zero left-shift) for the rounder.
// Latency: 2 cycles accept-to-out_valid, one result per cycle.
// Backpressure: skid-free pipeline; a stage advances when empty or its successor advances.
module fp_normalize
  import fp_normalize_pkg::*;
#(
  parameter int data_format = FMT_FP32
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_normalize_if.slave bus
);

  localparam int E   = get_exp_len(data_format);
  localparam int M   = get_mantissa_len(data_format);
  localparam int P   = get_protect_len(data_format);
  localparam int WI  = M + P + 2;
  localparam int W1  = M + P + 1;
  localparam int LZW = $clog2(W1 + 1);
  localparam int EX  = E + 1;
  localparam logic [EX-1:0] EXP_MAX = {1'b0, {E{1'b1}}};

  // Stage 1 state
  logic           r1_valid;
  logic [1:0]     r1_special;
  logic           r1_sign;
  logic [E-1:0]   r1_exp;
  logic [WI-1:0]  r1_mant;
  logic           r1_carry;
  logic           r1_zero;
  logic [LZW-1:0] r1_lz;

  // Stage 2 state (drives the outputs directly)
  logic           r2_valid;
  logic [1:0]     r2_special;
  logic           r2_sign;
  logic [E-1:0]   r2_exp;
  logic [W1-1:0]  r2_mant;

  logic           w_s1_adv;
  logic           w_s2_adv;
  logic [LZW-1:0] w_lz;
  logic [EX-1:0]  w_exp_x;
  logic [EX-1:0]  w_lz_x;
  logic [EX-1:0]  w_exp_inc;
  logic [EX-1:0]  w_exp_sub;
  logic [EX-1:0]  w_exp_dec;
  logic [1:0]     w_special_n;
  logic [E-1:0]   w_exp_n;
  logic [W1-1:0]  w_mant_n;

  assign w_s2_adv = ~r2_valid | bus.out_ready;
  assign w_s1_adv = ~r1_valid | w_s2_adv;

  // Count ignores the carry bit; carry takes priority in stage 2 anyway
  fp_lzc #(.W(W1)) u_lzc (
    .i_dat (bus.in_mant[W1-1:0]),
    .o_cnt (w_lz)
  );

  // Stage 1: capture operand and pre-decode carry/zero/leading zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid   <= 1'b0;
      r1_special <= '0;
      r1_sign    <= 1'b0;
      r1_exp     <= '0;
      r1_mant    <= '0;
      r1_carry   <= 1'b0;
      r1_zero    <= 1'b0;
      r1_lz      <= '0;
    end else if (w_s1_adv) begin
      r1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r1_special <= bus.in_special;
        r1_sign    <= bus.in_sign;
        r1_exp     <= bus.in_exp;
        r1_mant    <= bus.in_mant;
        r1_carry   <= bus.in_mant[WI-1];
        r1_zero    <= (bus.in_mant == '0);
        r1_lz      <= w_lz;
      end
    end
  end

  // Exponent math is one bit wider so increment/decrement never wraps
  assign w_exp_x   = {1'b0, r1_exp};
  assign w_lz_x    = EX'(r1_lz);
  assign w_exp_inc = w_exp_x + EX'(1);
  assign w_exp_sub = w_exp_x - w_lz_x;
  assign w_exp_dec = w_exp_x - EX'(1);

  // Stage 2 next-state: priority special > carry > zero > subnormal > shift
  always_comb begin
    w_special_n = r1_special;
    w_exp_n     = '0;
    w_mant_n    = '0;
    if (r1_special != SP_NORMAL) begin
      // rounder overrides exp/mant for specials
    end else if (r1_carry) begin
      w_mant_n = r1_mant[WI-1:1] | W1'(r1_mant[0]);
      if (w_exp_inc >= EXP_MAX) begin
        w_special_n = SP_INF;
        w_exp_n     = E'(EXP_MAX);
      end else begin
        w_exp_n = E'(w_exp_inc);
      end
    end else if (r1_zero) begin
      w_special_n = SP_ZERO;
    end else if (r1_exp == '0) begin
      w_mant_n = r1_mant[W1-1:0];
    end else if (w_lz_x < w_exp_x) begin
      w_mant_n = r1_mant[W1-1:0] << w_lz_x;
      w_exp_n  = E'(w_exp_sub);
    end else begin
      // only shift as far as the exponent allows, landing in subnormal range
      w_mant_n = r1_mant[W1-1:0] << w_exp_dec;
    end
  end

  // Stage 2: register the normalized result, hold while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid   <= 1'b0;
      r2_special <= '0;
      r2_sign    <= 1'b0;
      r2_exp     <= '0;
      r2_mant    <= '0;
    end else if (w_s2_adv) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_special <= w_special_n;
        r2_sign    <= r1_sign;
        r2_exp     <= w_exp_n;
        r2_mant    <= w_mant_n;
      end
    end
  end

  assign bus.in_ready    = w_s1_adv;
  assign bus.out_valid   = r2_valid;
  assign bus.out_special = r2_special;
  assign bus.out_sign    = r2_sign;
  assign bus.out_exp     = r2_exp;
  assign bus.out_mant    = r2_mant;

endmodule
